kf_meas_sequencer: RTL and testbench

Measurement front-end for the boost-converter Kalman filter. It drives the filter's `i_u`, `i_y` and `i_begin` inputs and consumes its `o_DV` output. It box-car averages raw ADC codes for input voltage (u) and output voltage (y), scales them to signed Q16.16 volts, and issues one filter start per sample period. It holds the operands stable until the filter reports done, and flags overruns, stale data and filter timeouts.

---
 rtl/kf_meas_sequencer_if.sv | 35 +++
 rtl/kf_meas_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_kf_meas_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf_meas_sequencer_if.sv
// Handshake/bus bundle between the measurement sequencer and its surroundings.
// Carries the ADC code stream in, the Kalman filter done pulse in, and the
// filter operands, start pulse and status flags out.
//   i_adc_valid/i_adc_ch/i_adc_code : raw ADC code strobe, channel (0 = u, 1 = y), code
//   i_kf_DV                         : filter done pulse
//   o_u/o_y                         : signed Q16.16 operands for the filter
//   o_begin                         : one-cycle filter start
//   o_busy/o_stale/o_timeout        : status flags
//   o_overrun_cnt                   : saturating count of dropped sample ticks
// The sequencer connects through the slave modport; the environment through master.
interface kf_meas_sequencer_if #(
  parameter int unsigned ADC_W = 12
);
  logic               i_adc_valid;
  logic               i_adc_ch;
  logic [ADC_W-1:0]   i_adc_code;
  logic               i_kf_DV;
  logic signed [31:0] o_u;
  logic signed [31:0] o_y;
  logic               o_begin;
  logic               o_busy;
  logic               o_stale;
  logic               o_timeout;
  logic [15:0]        o_overrun_cnt;

  modport master (
    output i_adc_valid, i_adc_ch, i_adc_code, i_kf_DV,
    input  o_u, o_y, o_begin, o_busy, o_stale, o_timeout, o_overrun_cnt
  );

  modport slave (
    input  i_adc_valid, i_adc_ch, i_adc_code, i_kf_DV,
    output o_u, o_y, o_begin, o_busy, o_stale, o_timeout, o_overrun_cnt
  );
endinterface

// File: rtl/kf_meas_sequencer.sv
// Measurement front-end for the boost-converter Kalman filter.
// Box-car averages 2**AVG_LOG2 ADC codes per channel (u, y) each sample period,
// scales the averages to signed Q16.16 volts, and issues one filter start per
// period. Operands hold stable until the filter reports done or times out.
// Ports:
//   i_clk : clock
//   i_rst : asynchronous active-high reset
//   bus   : kf_meas_sequencer_if slave (ADC stream, filter done, operands, status)
module kf_meas_sequencer #(
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned AVG_LOG2   = 2,
  parameter logic [31:0] U_GAIN     = 32'h0000_1000,
  parameter logic [31:0] Y_GAIN     = 32'h0000_1000,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic                 i_clk,
  input logic                 i_rst,
  kf_meas_sequencer_if.slave  bus
);

  localparam int unsigned SumW  = ADC_W + AVG_LOG2;
  localparam int unsigned CntW  = AVG_LOG2 + 1;
  localparam int unsigned ProdW = SumW + 32;
  localparam int unsigned TickW = $clog2(SAMPLE_DIV);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0]    CntFull = CntW'(2 ** AVG_LOG2);
  // Index 0 is the u channel, index 1 the y channel throughout.
  localparam logic [1:0][31:0]   Gain    = {Y_GAIN, U_GAIN};

  typedef enum logic [1:0] {StIdle, StScale, StIssue, StWaitDv} state_e;

  state_e                   state_q, state_d;
  logic [TickW-1:0]         tick_q;
  logic                     tick;
  logic [1:0]               hit;
  logic [1:0][SumW-1:0]     sum_q, sum_d;
  logic [1:0][CntW-1:0]     cnt_q, cnt_d;
  logic [1:0][SumW-1:0]     snap_sum_q;
  logic [1:0][CntW-1:0]     snap_cnt_q;
  logic                     snap_en;
  logic [1:0]               snap_full;
  logic [1:0][ProdW-1:0]    prod;
  logic [1:0][ProdW-1:0]    shifted;
  logic [1:0][31:0]         scaled;
  logic [ToW-1:0]           to_q, to_d;
  logic [1:0][31:0]         out_q, out_d;
  logic                     stale_q, stale_d;
  logic                     timeout_q, timeout_d;
  logic [15:0]              ovr_q, ovr_d;

  // Free-running sample-period counter.
  assign tick = (tick_q == TickW'(SAMPLE_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick ? '0 : tick_q + 1'b1;
    end
  end

  // Accumulation runs regardless of FSM state. A code arriving in the tick
  // cycle seeds the next period instead of joining the one being closed.
  assign hit = {bus.i_adc_valid & bus.i_adc_ch, bus.i_adc_valid & ~bus.i_adc_ch};

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    for (int c = 0; c < 2; c++) begin
      if (tick) begin
        sum_d[c] = hit[c] ? SumW'(bus.i_adc_code) : '0;
        cnt_d[c] = hit[c] ? CntW'(1) : '0;
      end else if (hit[c] && (cnt_q[c] < CntFull)) begin
        sum_d[c] = sum_q[c] + SumW'(bus.i_adc_code);
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  // Overrun ticks leave the previous snapshot untouched.
  assign snap_en = tick && (state_q == StIdle);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      snap_sum_q <= '0;
      snap_cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      if (snap_en) begin
        snap_sum_q <= sum_q;
        snap_cnt_q <= cnt_q;
      end
    end
  end

  // Full-width product so large gains saturate instead of wrapping.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      prod[c]    = ProdW'(snap_sum_q[c]) * ProdW'(Gain[c]);
      shifted[c] = prod[c] >> AVG_LOG2;
      scaled[c]  = (|shifted[c][ProdW-1:31]) ? 32'h7FFF_FFFF : {1'b0, shifted[c][30:0]};
    end
  end

  assign snap_full[0] = (snap_cnt_q[0] == CntFull);
  assign snap_full[1] = (snap_cnt_q[1] == CntFull);

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    out_d     = out_q;
    stale_d   = stale_q;
    timeout_d = timeout_q;
    ovr_d     = ovr_q;

    if (tick && (state_q != StIdle) && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StScale;
        end
      end
      StScale: begin
        // An incomplete channel keeps its last operand and flags the issue stale.
        for (int c = 0; c < 2; c++) begin
          if (snap_full[c]) begin
            out_d[c] = scaled[c];
          end
        end
        stale_d = ~&snap_full;
        state_d = StIssue;
      end
      StIssue: begin
        to_d    = '0;
        state_d = StWaitDv;
      end
      StWaitDv: begin
        if (bus.i_kf_DV) begin
          state_d = StIdle;
        end else if (to_q == ToW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      to_q      <= '0;
      out_q     <= '0;
      stale_q   <= 1'b0;
      timeout_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      out_q     <= out_d;
      stale_q   <= stale_d;
      timeout_q <= timeout_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.o_u           = out_q[0];
  assign bus.o_y           = out_q[1];
  assign bus.o_begin       = (state_q == StIssue);
  assign bus.o_busy        = (state_q != StIdle);
  assign bus.o_stale       = stale_q;
  assign bus.o_timeout     = timeout_q;
  assign bus.o_overrun_cnt = ovr_q;

endmodule

// File: tb/tb_kf_meas_sequencer.sv
// Directed-sequence bench with randomized ADC codes and filter latencies for
// kf_meas_sequencer (SAMPLE_DIV = 40, AVG_LOG2 = 2, unit gains of 1/16 V/LSB).
// A period-level reference model tracks accepted codes per channel in queues
// and predicts operands, start/busy windows, timeout and overrun counts.
module tb_kf_meas_sequencer;

  localparam int unsigned DIV  = 40;
  localparam logic [31:0] GAIN = 32'h0000_1000;

  logic clk;
  logic rst;

  kf_meas_sequencer_if #(.ADC_W(12)) bus ();

  kf_meas_sequencer #(
    .SAMPLE_DIV (DIV),
    .ADC_W      (12),
    .AVG_LOG2   (2),
    .U_GAIN     (GAIN),
    .Y_GAIN     (GAIN),
    .TIMEOUT    (64)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-period stimulus plan, indexed by cycle within the period.
  bit          plan_v    [DIV];
  bit          plan_ch   [DIV];
  logic [11:0] plan_code [DIV];

  // Reference model state.
  int          cyc;
  int          acc_u [$];
  int          acc_y [$];
  logic [31:0] m_u, m_y;
  bit          m_stale;
  int          m_busy_from, m_busy_to, m_begin_cyc, m_dv_cyc, m_timeout_at;
  int          m_ovr;
  int          dv_delay_cfg;  // filter latency after o_begin; 0 means never answers
  bit          stray_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int unsigned qsum(input int q[$]);
    int unsigned s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  // Average volts in Q16.16: mean code times gain, clipped to the positive range.
  function automatic logic [31:0] scale_ref(input int unsigned sum);
    longint unsigned p;
    p = (longint'(sum) * longint'(GAIN)) / 4;
    if (p > 64'h7FFF_FFFF) return 32'h7FFF_FFFF;
    return 32'(p);
  endfunction

  task automatic model_reset();
    cyc          = 0;
    acc_u.delete();
    acc_y.delete();
    m_u          = '0;
    m_y          = '0;
    m_stale      = 1'b0;
    m_busy_from  = -100;
    m_busy_to    = -100;
    m_begin_cyc  = -100;
    m_dv_cyc     = -100;
    m_timeout_at = 1 << 30;
    m_ovr        = 0;
    stray_dv     = 1'b0;
  endtask

  task automatic plan_clear();
    for (int i = 0; i < DIV; i++) begin
      plan_v[i]    = 1'b0;
      plan_ch[i]   = 1'b0;
      plan_code[i] = '0;
    end
  endtask

  task automatic plan_add(input int slot, input bit ch, input int code);
    plan_v[slot]    = 1'b1;
    plan_ch[slot]   = ch;
    plan_code[slot] = 12'(code);
  endtask

  // n random codes on one channel, every other cycle starting at first_slot.
  task automatic plan_rand(input bit ch, input int first_slot, input int n);
    for (int k = 0; k < n; k++) plan_add(first_slot + 2 * k, ch, int'($urandom_range(4095, 0)));
  endtask

  task automatic do_cycle();
    int ph;
    bit busy_now;
    bit full_u, full_y;
    ph       = cyc % DIV;
    busy_now = (cyc >= m_busy_from) && (cyc <= m_busy_to);

    chk("busy", 32'(bus.o_busy), 32'(busy_now));
    chk("begin", 32'(bus.o_begin), 32'(cyc == m_begin_cyc));
    chk("timeout", 32'(bus.o_timeout), 32'(cyc >= m_timeout_at));
    chk("overrun_cnt", 32'(bus.o_overrun_cnt), 32'(m_ovr));
    if ((cyc == m_begin_cyc) || (cyc == m_busy_to)) begin
      chk("o_u", bus.o_u, m_u);
      chk("o_y", bus.o_y, m_y);
      chk("stale", 32'(bus.o_stale), 32'(m_stale));
    end

    bus.i_adc_valid = plan_v[ph];
    bus.i_adc_ch    = plan_ch[ph];
    bus.i_adc_code  = plan_code[ph];
    bus.i_kf_DV     = stray_dv || (cyc == m_dv_cyc);

    if (ph == DIV - 1) begin
      if (busy_now) begin
        if (m_ovr < 65535) m_ovr++;
      end else begin
        full_u = (acc_u.size() == 4);
        full_y = (acc_y.size() == 4);
        if (full_u) m_u = scale_ref(qsum(acc_u));
        if (full_y) m_y = scale_ref(qsum(acc_y));
        m_stale     = !(full_u && full_y);
        m_busy_from = cyc + 1;
        m_begin_cyc = cyc + 2;
        if (dv_delay_cfg > 0) begin
          m_dv_cyc  = m_begin_cyc + dv_delay_cfg;
          m_busy_to = m_dv_cyc;
        end else begin
          m_dv_cyc  = -100;
          m_busy_to = m_begin_cyc + 64;
          if (m_timeout_at > m_busy_to + 1) m_timeout_at = m_busy_to + 1;
        end
      end
      acc_u.delete();
      acc_y.delete();
      if (plan_v[ph]) begin
        if (plan_ch[ph]) acc_y.push_back(int'(plan_code[ph]));
        else             acc_u.push_back(int'(plan_code[ph]));
      end
    end else if (plan_v[ph]) begin
      if (plan_ch[ph]) begin
        if (acc_y.size() < 4) acc_y.push_back(int'(plan_code[ph]));
      end else begin
        if (acc_u.size() < 4) acc_u.push_back(int'(plan_code[ph]));
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_period();
    repeat (DIV) do_cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_u"}, bus.o_u, 32'h0);
    chk({tag, "_y"}, bus.o_y, 32'h0);
    chk({tag, "_begin"}, 32'(bus.o_begin), 32'h0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'h0);
    chk({tag, "_stale"}, 32'(bus.o_stale), 32'h0);
    chk({tag, "_timeout"}, 32'(bus.o_timeout), 32'h0);
    chk({tag, "_overrun"}, 32'(bus.o_overrun_cnt), 32'h0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_adc_valid = 1'b0;
    bus.i_adc_ch    = 1'b0;
    bus.i_adc_code  = '0;
    bus.i_kf_DV     = 1'b0;
    dv_delay_cfg    = 29;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    cyc = 0;

    // Nominal scale: 560 -> 35.0 V, 1280 -> 80.0 V, filter answers after 29 cycles.
    plan_clear();
    for (int k = 0; k < 4; k++) begin
      plan_add(2 + 2 * k, 1'b0, 560);
      plan_add(3 + 2 * k, 1'b1, 1280);
    end
    dv_delay_cfg = 29;
    run_period();

    // Averaging with an excess fifth y code.
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_add(3, 1'b1, 1000);
    plan_add(5, 1'b1, 1002);
    plan_add(7, 1'b1, 1004);
    plan_add(9, 1'b1, 1006);
    plan_add(11, 1'b1, 4000);
    dv_delay_cfg = int'($urandom_range(30, 1));
    run_period();
    chk("nominal_u_literal", bus.o_u, 32'h0023_0000);
    chk("nominal_y_literal", bus.o_y, 32'h0050_0000);

    // Missing y sample: y kept, stale raised.
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 3);
    dv_delay_cfg = int'($urandom_range(30, 1));
    run_period();
    chk("avg_y_literal", bus.o_y, 32'h003E_B000);

    // Full period clears stale; y code in the tick cycle seeds the next period.
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 4);
    plan_add(DIV - 1, 1'b1, 2000);
    dv_delay_cfg = int'($urandom_range(30, 1));
    run_period();
    chk("stale_y_kept_literal", bus.o_y, 32'h003E_B000);
    chk("stale_literal", 32'(bus.o_stale), 32'h1);

    // Three y codes plus the carried 2000 make a full period; filter never answers.
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 3);
    dv_delay_cfg = 0;
    run_period();

    // Tick lands during WAIT_DV: overrun, no issue.
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 4);
    run_period();
    chk("overrun_literal", 32'(bus.o_overrun_cnt), 32'h1);

    // Next tick finds the FSM idle and issues normally.
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 4);
    dv_delay_cfg = int'($urandom_range(30, 1));
    run_period();
    chk("timeout_sticky_literal", 32'(bus.o_timeout), 32'h1);

    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 4);
    dv_delay_cfg = 29;
    run_period();

    // Reset asserted asynchronously while waiting for the filter.
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 4);
    repeat (10) do_cycle();
    chk("pre_reset_busy", 32'(bus.o_busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    bus.i_adc_valid = 1'b0;
    bus.i_kf_DV     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Late filter done after release must be ignored; first issue after a full period.
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 4);
    dv_delay_cfg = int'($urandom_range(30, 1));
    stray_dv = 1'b1;
    repeat (3) do_cycle();
    stray_dv = 1'b0;
    repeat (DIV - 3) do_cycle();
    plan_clear();
    plan_rand(1'b0, 2, 4);
    plan_rand(1'b1, 3, 4);
    run_period();
    run_period();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
